// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: +1 or table-offset stepping, start/halt run control, run-cycle counter.
// All outputs registered (1-cycle latency from inputs); stall freezes the PC but not the cycle counter.
module pc_sequencer #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [D-1:0]  start_addr_i,
  input  logic          branch_i,
  input  logic [2:0]    how_high_i,
  input  logic          halt_i,
  input  logic          stall_i,
  input  logic          cfg_we_i,
  input  logic [2:0]    cfg_idx_i,
  input  logic [D-1:0]  cfg_data_i,
  output logic [D-1:0]  prog_ctr_o,
  output logic          running_o,
  output logic          done_o,
  output logic [CW-1:0] cycle_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [D-1:0] OFF_M5  = {D{1'b1}} - D'(4);
  localparam logic [D-1:0] OFF_P20 = D'(20);
  localparam logic [D-1:0] OFF_M1  = {D{1'b1}};

  state_t          state_q, state_d;
  logic [D-1:0]    pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic [D-1:0]    tbl_q [8];

  // Writes land at the edge, so a same-cycle branch still reads the old entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 8; i++) begin
        tbl_q[i] <= '0;
      end
      tbl_q[0] <= OFF_M5;
      tbl_q[1] <= OFF_P20;
      tbl_q[2] <= OFF_M1;
    end else if (cfg_we_i) begin
      tbl_q[cfg_idx_i] <= cfg_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          pc_d    = start_addr_i;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (!stall_i) begin
          if (halt_i) begin
            state_d = S_DONE;
          end else if (branch_i) begin
            pc_d = pc_q + tbl_q[how_high_i];
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign prog_ctr_o  = pc_q;
  assign running_o   = running_q;
  assign done_o      = done_q;
  assign cycle_cnt_o = cnt_q;

endmodule
